// File: rtl/multicycle_control_unit_if.sv
// Bundle of datapath inputs and control outputs between the VMI multicycle
// controller (master) and the datapath/memory side (slave).
interface multicycle_control_unit_if #(
    parameter int OPCODE_W = 8
);
    // Memory handshake: memReq stays high for the whole access and memWrite
    // qualifies it as a store. A one-cycle memReady pulse while memReq is high
    // completes the access. memReady is ignored when memReq is low.
    logic [OPCODE_W-1:0] opcode;
    logic                zero;
    logic                memReady;

    logic                pcWrite;
    logic [1:0]          pcSrc;
    logic                irWrite;
    logic                regWrite;
    logic                aluSrcA;
    logic                aluSrcB;
    logic [1:0]          aluControl;
    logic [1:0]          resultSrc;
    logic                memReq;
    logic                memWrite;
    logic                retire;
    logic                trap;
    logic [1:0]          trapCause;

    modport master (
        input  opcode, zero, memReady,
        output pcWrite, pcSrc, irWrite, regWrite, aluSrcA, aluSrcB,
               aluControl, resultSrc, memReq, memWrite, retire, trap, trapCause
    );

    modport slave (
        output opcode, zero, memReady,
        input  pcWrite, pcSrc, irWrite, regWrite, aluSrcA, aluSrcB,
               aluControl, resultSrc, memReq, memWrite, retire, trap, trapCause
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multicycle VMI controller: sequences fetch/decode/execute/memory/branch,
// times out stalled memory accesses and traps on illegal opcodes.
module multicycle_control_unit #(
    parameter int OPCODE_W        = 8,
    parameter int MEM_TIMEOUT     = 15,
    parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    multicycle_control_unit_if.master bus,
    output logic [2:0]                dbgState
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM_RD = 3'd4,
        MEM_WR = 3'd5,
        BRANCH = 3'd6,
        TRAP   = 3'd7
    } stateType;

    localparam logic [4:0] OP_NOP   = 5'h00;
    localparam logic [4:0] OP_ADD_R = 5'h01;
    localparam logic [4:0] OP_ADD_I = 5'h02;
    localparam logic [4:0] OP_SUB_R = 5'h03;
    localparam logic [4:0] OP_SUB_I = 5'h04;
    localparam logic [4:0] OP_AND_R = 5'h05;
    localparam logic [4:0] OP_AND_I = 5'h06;
    localparam logic [4:0] OP_OR_R  = 5'h07;
    localparam logic [4:0] OP_OR_I  = 5'h08;
    localparam logic [4:0] OP_MOV_R = 5'h09;
    localparam logic [4:0] OP_MOV_I = 5'h0A;
    localparam logic [4:0] OP_LDR   = 5'h0B;
    localparam logic [4:0] OP_STR   = 5'h0C;
    localparam logic [4:0] OP_B     = 5'h0D;
    localparam logic [4:0] OP_BEQ   = 5'h0E;
    localparam logic [4:0] OP_BNE   = 5'h0F;
    localparam logic [4:0] OP_BL    = 5'h10;
    localparam logic [4:0] OP_BRN   = 5'h11;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    localparam logic [1:0] PC_PLUS1  = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_REG    = 2'b10;

    localparam logic [1:0] RES_MEM  = 2'b01;
    localparam logic [1:0] RES_LINK = 2'b10;

    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

    stateType         state, nextState;
    logic [CNT_W-1:0] waitCnt, waitCntNext;
    logic [1:0]       trapCause, trapCauseNext;

    logic [4:0] op5;
    logic       legal;
    logic       timedOut;

    logic       pcWrite;
    logic [1:0] pcSrc;
    logic       irWrite;
    logic       regWrite;
    logic       aluSrcA;
    logic       aluSrcB;
    logic [1:0] aluControl;
    logic [1:0] resultSrc;
    logic       memReq;
    logic       memWrite;
    logic       retire;
    logic       trap;

    assign op5      = bus.opcode[4:0];
    // Any bit above the 5-bit opcode space makes the instruction illegal.
    assign legal    = ((bus.opcode >> 5) == '0) && (op5 <= OP_BRN);
    assign timedOut = (waitCnt == CNT_W'(MEM_TIMEOUT));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            waitCnt   <= '0;
            trapCause <= 2'b00;
        end else begin
            state     <= nextState;
            waitCnt   <= waitCntNext;
            trapCause <= trapCauseNext;
        end
    end

    always_comb begin
        nextState     = state;
        waitCntNext   = '0;
        trapCauseNext = trapCause;
        pcWrite       = 1'b0;
        pcSrc         = PC_PLUS1;
        irWrite       = 1'b0;
        regWrite      = 1'b0;
        aluSrcA       = 1'b0;
        aluSrcB       = 1'b0;
        aluControl    = ALU_ADD;
        resultSrc     = 2'b00;
        memReq        = 1'b0;
        memWrite      = 1'b0;
        retire        = 1'b0;
        trap          = 1'b0;

        case (state)
            IDLE: nextState = FETCH;

            // The wait counter only survives while an access keeps waiting,
            // so every entry into a memory state starts it from zero.
            FETCH: begin
                memReq = 1'b1;
                if (bus.memReady) begin
                    irWrite   = 1'b1;
                    pcWrite   = 1'b1;
                    nextState = DECODE;
                end else if (timedOut) begin
                    nextState     = TRAP;
                    trapCauseNext = CAUSE_TIMEOUT;
                end else begin
                    waitCntNext = waitCnt + 1'b1;
                end
            end

            DECODE: begin
                if (!legal) begin
                    if (TRAP_ON_ILLEGAL) begin
                        nextState     = TRAP;
                        trapCauseNext = CAUSE_ILLEGAL;
                    end else begin
                        retire    = 1'b1;
                        nextState = FETCH;
                    end
                end else begin
                    case (op5)
                        OP_NOP: begin
                            retire    = 1'b1;
                            nextState = FETCH;
                        end
                        OP_LDR:  nextState = MEM_RD;
                        OP_STR:  nextState = MEM_WR;
                        OP_B, OP_BEQ, OP_BNE, OP_BL, OP_BRN: nextState = BRANCH;
                        default: nextState = EXEC;
                    endcase
                end
            end

            EXEC: begin
                regWrite  = 1'b1;
                retire    = 1'b1;
                nextState = FETCH;
                case (op5)
                    OP_ADD_I: aluSrcB = 1'b1;
                    OP_SUB_R: aluControl = ALU_SUB;
                    OP_SUB_I: begin
                        aluControl = ALU_SUB;
                        aluSrcB    = 1'b1;
                    end
                    OP_AND_R: aluControl = ALU_AND;
                    OP_AND_I: begin
                        aluControl = ALU_AND;
                        aluSrcB    = 1'b1;
                    end
                    OP_OR_R: aluControl = ALU_OR;
                    OP_OR_I: begin
                        aluControl = ALU_OR;
                        aluSrcB    = 1'b1;
                    end
                    OP_MOV_R: aluSrcA = 1'b1;
                    OP_MOV_I: begin
                        aluSrcA = 1'b1;
                        aluSrcB = 1'b1;
                    end
                    default: aluControl = ALU_ADD;
                endcase
            end

            MEM_RD: begin
                aluSrcB = 1'b1;
                memReq  = 1'b1;
                if (bus.memReady) begin
                    regWrite  = 1'b1;
                    resultSrc = RES_MEM;
                    retire    = 1'b1;
                    nextState = FETCH;
                end else if (timedOut) begin
                    nextState     = TRAP;
                    trapCauseNext = CAUSE_TIMEOUT;
                end else begin
                    waitCntNext = waitCnt + 1'b1;
                end
            end

            MEM_WR: begin
                aluSrcB  = 1'b1;
                memReq   = 1'b1;
                memWrite = 1'b1;
                if (bus.memReady) begin
                    retire    = 1'b1;
                    nextState = FETCH;
                end else if (timedOut) begin
                    nextState     = TRAP;
                    trapCauseNext = CAUSE_TIMEOUT;
                end else begin
                    waitCntNext = waitCnt + 1'b1;
                end
            end

            BRANCH: begin
                retire    = 1'b1;
                nextState = FETCH;
                case (op5)
                    OP_B: begin
                        pcWrite = 1'b1;
                        pcSrc   = PC_BRANCH;
                    end
                    OP_BEQ: begin
                        aluControl = ALU_SUB;
                        pcWrite    = bus.zero;
                        pcSrc      = PC_BRANCH;
                    end
                    OP_BNE: begin
                        aluControl = ALU_SUB;
                        pcWrite    = ~bus.zero;
                        pcSrc      = PC_BRANCH;
                    end
                    OP_BL: begin
                        pcWrite   = 1'b1;
                        pcSrc     = PC_BRANCH;
                        regWrite  = 1'b1;
                        resultSrc = RES_LINK;
                    end
                    OP_BRN: begin
                        pcWrite = 1'b1;
                        pcSrc   = PC_REG;
                    end
                    default: pcSrc = PC_PLUS1;
                endcase
            end

            TRAP: begin
                trap      = 1'b1;
                nextState = TRAP;
            end

            default: nextState = IDLE;
        endcase
    end

    assign bus.pcWrite    = pcWrite;
    assign bus.pcSrc      = pcSrc;
    assign bus.irWrite    = irWrite;
    assign bus.regWrite   = regWrite;
    assign bus.aluSrcA    = aluSrcA;
    assign bus.aluSrcB    = aluSrcB;
    assign bus.aluControl = aluControl;
    assign bus.resultSrc  = resultSrc;
    assign bus.memReq     = memReq;
    assign bus.memWrite   = memWrite;
    assign bus.retire     = retire;
    assign bus.trap       = trap;
    assign bus.trapCause  = trapCause;
    assign dbgState       = state;

endmodule
